// File: rtl/rv_run_ctrl.sv
// Debug run-control sequencer: halt/resume/single-step/PC breakpoint via a fetch freeze,
// plus a retired-instruction counter. Optional retire trace enabled by RV_RUN_CTRL_TRACE_EN.
module rv_run_ctrl #(
  parameter int DRAIN_CYCLES = 5,
  parameter int RETIRE_W     = 32,
  parameter int RESET_HALTED = 0
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_commit_valid,
  input  logic [31:0]         i_commit_pc,
  input  logic                i_fetch_fire,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [2:0]          i_cmd_op,
  input  logic [31:0]         i_cmd_arg,
  output logic                o_fetch_stall,
  output logic                o_halted,
  output logic [1:0]          o_halt_cause,
  output logic                o_bp_active,
  output logic [RETIRE_W-1:0] o_retire_cnt
`ifdef RV_RUN_CTRL_TRACE_EN
  ,
  output logic [31:0]         o_last_pc,
  output logic                o_last_valid
`endif
);

  localparam logic [1:0] S_RUN        = 2'd0;
  localparam logic [1:0] S_DRAIN      = 2'd1;
  localparam logic [1:0] S_HALTED     = 2'd2;
  localparam logic [1:0] S_STEP_ISSUE = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_CMD  = 2'd1;
  localparam logic [1:0] CAUSE_BP   = 2'd2;
  localparam logic [1:0] CAUSE_STEP = 2'd3;

  localparam logic [2:0] OP_HALT   = 3'd0;
  localparam logic [2:0] OP_RESUME = 3'd1;
  localparam logic [2:0] OP_STEP   = 3'd2;
  localparam logic [2:0] OP_SET_BP = 3'd3;
  localparam logic [2:0] OP_CLR_BP = 3'd4;

  localparam logic [1:0] S_RESET     = (RESET_HALTED != 0) ? S_HALTED : S_RUN;
  localparam logic [1:0] CAUSE_RESET = (RESET_HALTED != 0) ? CAUSE_CMD : CAUSE_NONE;

  // Drain counter must be at least one bit wide even when DRAIN_CYCLES is 1.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0]       DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0]       DRAIN_ONE  = DW'(1);
  localparam logic [RETIRE_W-1:0] RETIRE_ONE = RETIRE_W'(1);

  logic [1:0]          r_state;
  logic [1:0]          r_pending_cause;
  logic [1:0]          r_halt_cause;
  logic [DW-1:0]       r_drain_cnt;
  logic                r_bp_active;
  logic [31:0]         r_bp_addr;
  logic [RETIRE_W-1:0] r_retire_cnt;

  logic [1:0]          w_state_next;
  logic [1:0]          w_pending_next;
  logic [1:0]          w_halt_cause_next;
  logic                w_load_drain;
  logic                w_bp_active_next;
  logic [31:0]         w_bp_addr_next;
  logic                w_cmd_ready;
  logic                w_cmd_fire;
  logic                w_bp_hit;

  assign w_cmd_ready = (r_state == S_RUN) || (r_state == S_HALTED);
  assign w_cmd_fire  = i_cmd_valid && w_cmd_ready;
  assign w_bp_hit    = r_bp_active && i_commit_valid && (i_commit_pc == r_bp_addr);

  always_comb begin
    w_state_next      = r_state;
    w_pending_next    = r_pending_cause;
    w_halt_cause_next = r_halt_cause;
    w_load_drain      = 1'b0;
    case (r_state)
      S_RUN: begin
        // A breakpoint hit outranks a simultaneous HALT; the HALT is still consumed.
        if (w_bp_hit) begin
          w_state_next   = S_DRAIN;
          w_pending_next = CAUSE_BP;
          w_load_drain   = 1'b1;
        end else if (w_cmd_fire && (i_cmd_op == OP_HALT)) begin
          w_state_next   = S_DRAIN;
          w_pending_next = CAUSE_CMD;
          w_load_drain   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) begin
          w_state_next      = S_HALTED;
          w_halt_cause_next = r_pending_cause;
        end
      end
      S_HALTED: begin
        if (w_cmd_fire && (i_cmd_op == OP_RESUME)) begin
          w_state_next      = S_RUN;
          w_halt_cause_next = CAUSE_NONE;
        end else if (w_cmd_fire && (i_cmd_op == OP_STEP)) begin
          w_state_next = S_STEP_ISSUE;
        end
      end
      S_STEP_ISSUE: begin
        if (i_fetch_fire) begin
          w_state_next   = S_DRAIN;
          w_pending_next = CAUSE_STEP;
          w_load_drain   = 1'b1;
        end
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  always_comb begin
    w_bp_active_next = r_bp_active;
    w_bp_addr_next   = r_bp_addr;
    if (w_cmd_fire && (i_cmd_op == OP_SET_BP)) begin
      w_bp_active_next = 1'b1;
      w_bp_addr_next   = i_cmd_arg;
    end else if (w_cmd_fire && (i_cmd_op == OP_CLR_BP)) begin
      w_bp_active_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state         <= S_RESET;
      r_pending_cause <= CAUSE_NONE;
      r_halt_cause    <= CAUSE_RESET;
    end else begin
      r_state         <= w_state_next;
      r_pending_cause <= w_pending_next;
      r_halt_cause    <= w_halt_cause_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_drain_cnt <= '0;
    end else if (w_load_drain) begin
      r_drain_cnt <= DRAIN_LOAD;
    end else if ((r_state == S_DRAIN) && (r_drain_cnt != '0)) begin
      r_drain_cnt <= r_drain_cnt - DRAIN_ONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_bp_active <= 1'b0;
      r_bp_addr   <= '0;
    end else begin
      r_bp_active <= w_bp_active_next;
      r_bp_addr   <= w_bp_addr_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_retire_cnt <= '0;
    end else if (i_commit_valid) begin
      r_retire_cnt <= r_retire_cnt + RETIRE_ONE;
    end
  end

`ifdef RV_RUN_CTRL_TRACE_EN
  logic [31:0] r_last_pc;
  logic        r_last_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last_pc    <= '0;
      r_last_valid <= 1'b0;
    end else if (i_commit_valid) begin
      r_last_pc    <= i_commit_pc;
      r_last_valid <= 1'b1;
    end
  end

  assign o_last_pc    = r_last_pc;
  assign o_last_valid = r_last_valid;
`endif

  assign o_cmd_ready   = w_cmd_ready;
  assign o_fetch_stall = (r_state == S_DRAIN) || (r_state == S_HALTED);
  assign o_halted      = (r_state == S_HALTED);
  assign o_halt_cause  = r_halt_cause;
  assign o_bp_active   = r_bp_active;
  assign o_retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Directed bench for rv_run_ctrl: reset, halt/drain, breakpoint, single-step, counter wrap,
// and asynchronous reset during drain. Trace outputs checked when RV_RUN_CTRL_TRACE_EN is defined.
module tb_rv_run_ctrl;

  logic        clk;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        fetch_fire;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_arg;

  logic        w_cmd_ready;
  logic        w_fetch_stall;
  logic        w_halted;
  logic [1:0]  w_halt_cause;
  logic        w_bp_active;
  logic [3:0]  w_retire_cnt;

  logic        h_cmd_ready;
  logic        h_fetch_stall;
  logic        h_halted;
  logic [1:0]  h_halt_cause;
  logic        h_bp_active;
  logic [7:0]  h_retire_cnt;

`ifdef RV_RUN_CTRL_TRACE_EN
  logic [31:0] w_last_pc;
  logic        w_last_valid;
  logic [31:0] h_last_pc;
  logic        h_last_valid;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] exp_ret;

  rv_run_ctrl #(.DRAIN_CYCLES(5), .RETIRE_W(4), .RESET_HALTED(0)) u_dut (
    .i_clk(clk), .i_reset(rst),
    .i_commit_valid(commit_valid), .i_commit_pc(commit_pc),
    .i_fetch_fire(fetch_fire),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(w_cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg),
    .o_fetch_stall(w_fetch_stall), .o_halted(w_halted),
    .o_halt_cause(w_halt_cause), .o_bp_active(w_bp_active),
    .o_retire_cnt(w_retire_cnt)
`ifdef RV_RUN_CTRL_TRACE_EN
    , .o_last_pc(w_last_pc), .o_last_valid(w_last_valid)
`endif
  );

  rv_run_ctrl #(.DRAIN_CYCLES(1), .RETIRE_W(8), .RESET_HALTED(1)) u_dut_rh (
    .i_clk(clk), .i_reset(rst),
    .i_commit_valid(commit_valid), .i_commit_pc(commit_pc),
    .i_fetch_fire(fetch_fire),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(h_cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_arg(cmd_arg),
    .o_fetch_stall(h_fetch_stall), .o_halted(h_halted),
    .o_halt_cause(h_halt_cause), .o_bp_active(h_bp_active),
    .o_retire_cnt(h_retire_cnt)
`ifdef RV_RUN_CTRL_TRACE_EN
    , .o_last_pc(h_last_pc), .o_last_valid(h_last_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; all sampling and driving happens 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
    $display("cmd op=%0d arg=0x%08h stall=%0d halted=%0d", op, arg, w_fetch_stall, w_halted);
  endtask

  task automatic commit(input logic [31:0] pc);
    commit_valid = 1'b1;
    commit_pc    = pc;
    tick();
    commit_valid = 1'b0;
    exp_ret      = exp_ret + 4'd1;
    $display("commit pc=0x%08h retire_cnt=%0d", pc, w_retire_cnt);
  endtask

  initial begin
    rst = 1'b1; commit_valid = 1'b0; commit_pc = '0; fetch_fire = 1'b0;
    cmd_valid = 1'b0; cmd_op = 3'd7; cmd_arg = '0;
    exp_ret = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state of both configurations
    chk("rst_stall",  {31'd0, w_fetch_stall}, 32'd0);
    chk("rst_halted", {31'd0, w_halted},      32'd0);
    chk("rst_cause",  {30'd0, w_halt_cause},  32'd0);
    chk("rst_retire", {28'd0, w_retire_cnt},  32'd0);
    chk("rst_bp",     {31'd0, w_bp_active},   32'd0);
    chk("rst_ready",  {31'd0, w_cmd_ready},   32'd1);
    chk("rh_halted",  {31'd0, h_halted},      32'd1);
    chk("rh_stall",   {31'd0, h_fetch_stall}, 32'd1);
    chk("rh_cause",   {30'd0, h_halt_cause},  32'd1);

    // HALT from RUN: stall next cycle, halted exactly 5 edges after acceptance
    send_cmd(3'd0, 32'd0);
    chk("halt_stall0", {31'd0, w_fetch_stall}, 32'd1);
    chk("halt_ready0", {31'd0, w_cmd_ready},   32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("halt_drain%0d_halted", k), {31'd0, w_halted},    32'd0);
      chk($sformatf("halt_drain%0d_ready", k),  {31'd0, w_cmd_ready}, 32'd0);
    end
    tick();
    chk("halt_done",  {31'd0, w_halted},     32'd1);
    chk("halt_cause", {30'd0, w_halt_cause}, 32'd1);
    chk("halt_ready", {31'd0, w_cmd_ready},  32'd1);

    // RESUME from HALTED
    send_cmd(3'd1, 32'd0);
    chk("resume_stall", {31'd0, w_fetch_stall}, 32'd0);
    chk("resume_cause", {30'd0, w_halt_cause},  32'd0);

    // Breakpoint at 0x10 with a simultaneous HALT on the hitting cycle
    send_cmd(3'd3, 32'h0000_0010);
    chk("bp_armed", {31'd0, w_bp_active}, 32'd1);
    for (int i = 0; i < 4; i++) commit(32'(i * 4));
    chk("bp_prehit_stall", {31'd0, w_fetch_stall}, 32'd0);
    commit_valid = 1'b1; commit_pc = 32'h10;
    cmd_valid = 1'b1; cmd_op = 3'd0;
    tick();
    commit_valid = 1'b0; cmd_valid = 1'b0;
    exp_ret = exp_ret + 4'd1;
    $display("commit pc=0x00000010 with HALT retire_cnt=%0d", w_retire_cnt);
    chk("bp_hit_stall", {31'd0, w_fetch_stall}, 32'd1);
    tick();
    commit(32'h10);   // hit during drain is ignored
    tick(); tick();
    chk("bp_drain_halted", {31'd0, w_halted}, 32'd0);
    tick();
    chk("bp_halted", {31'd0, w_halted},     32'd1);
    chk("bp_cause",  {30'd0, w_halt_cause}, 32'd2);
    chk("bp_retire", {28'd0, w_retire_cnt}, {28'd0, exp_ret});

    // Single step with fetch_fire delayed three cycles
    send_cmd(3'd2, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("step_wait%0d_stall", k), {31'd0, w_fetch_stall}, 32'd0);
      chk($sformatf("step_wait%0d_ready", k), {31'd0, w_cmd_ready},   32'd0);
      tick();
    end
    fetch_fire = 1'b1;
    tick();
    fetch_fire = 1'b0;
    chk("step_drain_stall", {31'd0, w_fetch_stall}, 32'd1);
    commit(32'h14);
    tick(); tick(); tick();
    chk("step_drain_halted", {31'd0, w_halted}, 32'd0);
    tick();
    chk("step_halted", {31'd0, w_halted},     32'd1);
    chk("step_cause",  {30'd0, w_halt_cause}, 32'd3);
    chk("step_retire", {28'd0, w_retire_cnt}, {28'd0, exp_ret});
`ifdef RV_RUN_CTRL_TRACE_EN
    chk("trace_pc",    w_last_pc,               32'h14);
    chk("trace_valid", {31'd0, w_last_valid},   32'd1);
`endif

    send_cmd(3'd1, 32'd0);
    chk("resume2_stall", {31'd0, w_fetch_stall}, 32'd0);
    chk("resume2_cause", {30'd0, w_halt_cause},  32'd0);
    send_cmd(3'd4, 32'd0);
    chk("bp_cleared", {31'd0, w_bp_active}, 32'd0);

    // Asynchronous reset in the middle of a drain
    send_cmd(3'd3, 32'h0000_0040);
    send_cmd(3'd0, 32'd0);
    tick();
    chk("pre_rst_stall", {31'd0, w_fetch_stall}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_stall",  {31'd0, w_fetch_stall}, 32'd0);
    chk("arst_bp",     {31'd0, w_bp_active},   32'd0);
    chk("arst_ready",  {31'd0, w_cmd_ready},   32'd1);
    chk("arst_retire", {28'd0, w_retire_cnt},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 4'd0;
    tick(); tick();
    chk("post_rst_stall", {31'd0, w_fetch_stall}, 32'd0);
    chk("post_rst_cause", {30'd0, w_halt_cause},  32'd0);

    // 17 commits wrap the 4-bit counter to 1; pc 0x40 must not halt after reset
    for (int i = 0; i < 15; i++) commit(32'h30 + 32'(i * 4));
    chk("retire_max", {28'd0, w_retire_cnt}, 32'd15);
    commit(32'h100);
    commit(32'h104);
    chk("retire_wrap", {28'd0, w_retire_cnt}, 32'd1);
    chk("retire_model", {28'd0, w_retire_cnt}, {28'd0, exp_ret});
    chk("no_bp_after_rst", {31'd0, w_fetch_stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
